divide_by_n: RTL and testbench

Parametrised, runtime-programmable integer clock-enable divider. Generalises the fixed divide-by-3 Moore FSM to any divisor N in 1..2^WIDTH-1, with two output modes and glitch-free divisor changes. Sits next to the other chapter-4 FSMs. It produces a derived enable/strobe in the `clk` domain; it does not generate a new clock.

---
 rtl/divn_pkg.sv | 21 ++
 rtl/divn_shadow.sv | 72 +++++++
 rtl/divide_by_n.sv | 82 ++++++++
 tb/tb_divide_by_n.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/divn_pkg.sv
// Shared types and helpers for the runtime-programmable clock-enable divider.
// Helpers work at a fixed 32-bit width so any WIDTH up to 32 can use them.
package divn_pkg;

    typedef enum logic {
        DIVN_PULSE  = 1'b0,
        DIVN_SQUARE = 1'b1
    } divn_mode_t;

    localparam int DIVN_MAX_W = 32;

    function automatic logic [DIVN_MAX_W-1:0] divn_eff(input logic [DIVN_MAX_W-1:0] div);
        return (div == '0) ? DIVN_MAX_W'(1) : div;
    endfunction

    // One extra bit keeps ceil(n/2) exact even for the largest divisor.
    function automatic logic [DIVN_MAX_W:0] divn_half(input logic [DIVN_MAX_W-1:0] n);
        return ({1'b0, n} + (DIVN_MAX_W+1)'(1)) >> 1;
    endfunction

endpackage

// File: rtl/divn_shadow.sv
// Shadow register for divisor/mode updates: holds a pending request and
// moves it to the active settings only on an apply edge (wrap or idle at 0).
module divn_shadow
    import divn_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_DIV  = 3,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    input  logic             apply,
    output logic [WIDTH-1:0] div_act,
    output divn_mode_t       mode_act,
    output logic             pend_valid
);

    localparam divn_mode_t RESET_MODE = (DEFAULT_MODE != 0) ? DIVN_SQUARE : DIVN_PULSE;

    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    divn_mode_t       mode_act_q, mode_act_d;
    divn_mode_t       mode_pend_q, mode_pend_d;
    logic             pend_valid_q, pend_valid_d;

    // A load coinciding with an apply edge bypasses the shadow entirely.
    always_comb begin
        div_act_d    = div_act_q;
        mode_act_d   = mode_act_q;
        div_pend_d   = div_pend_q;
        mode_pend_d  = mode_pend_q;
        pend_valid_d = pend_valid_q;
        if (apply) begin
            if (div_load) begin
                div_act_d  = div_in;
                mode_act_d = divn_mode_t'(mode_in);
            end else if (pend_valid_q) begin
                div_act_d  = div_pend_q;
                mode_act_d = mode_pend_q;
            end
            pend_valid_d = 1'b0;
        end else if (div_load) begin
            div_pend_d   = div_in;
            mode_pend_d  = divn_mode_t'(mode_in);
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_act_q    <= WIDTH'(DEFAULT_DIV);
            mode_act_q   <= RESET_MODE;
            div_pend_q   <= '0;
            mode_pend_q  <= DIVN_PULSE;
            pend_valid_q <= 1'b0;
        end else begin
            div_act_q    <= div_act_d;
            mode_act_q   <= mode_act_d;
            div_pend_q   <= div_pend_d;
            mode_pend_q  <= mode_pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign div_act    = div_act_q;
    assign mode_act   = mode_act_q;
    assign pend_valid = pend_valid_q;

endmodule

// File: rtl/divide_by_n.sv
// Runtime-programmable divide-by-N enable generator (pulse or square output).
// Defining DIVN_PHASE_OUT_EN exposes the internal counter on port 'phase'.
module divide_by_n
    import divn_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_DIV  = 3,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    output logic             y,
    output logic             tick,
    output logic             busy
`ifdef DIVN_PHASE_OUT_EN
    ,
    output logic [WIDTH-1:0] phase
`endif
);

    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      div_act;
    divn_mode_t            mode_act;
    logic                  pend_valid;
    logic [DIVN_MAX_W-1:0] effN;
    logic [DIVN_MAX_W:0]   halfN;
    logic                  atEnd;
    logic                  apply;

    divn_shadow #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV),
        .DEFAULT_MODE(DEFAULT_MODE)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .div_load  (div_load),
        .div_in    (div_in),
        .mode_in   (mode_in),
        .apply     (apply),
        .div_act   (div_act),
        .mode_act  (mode_act),
        .pend_valid(pend_valid)
    );

    // New settings only land while cnt is 0 after the edge, so periods are never cut short.
    always_comb begin
        effN  = divn_eff(DIVN_MAX_W'(div_act));
        halfN = divn_half(effN);
        atEnd = (DIVN_MAX_W'(cnt_q) == (effN - DIVN_MAX_W'(1)));
        tick  = en && atEnd;
        apply = tick || (!en && (cnt_q == '0));
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = atEnd ? '0 : cnt_q + WIDTH'(1);
        end
        if (mode_act == DIVN_SQUARE) begin
            y = ((DIVN_MAX_W+1)'(cnt_q) < halfN);
        end else begin
            y = (cnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = pend_valid;

`ifdef DIVN_PHASE_OUT_EN
    assign phase = cnt_q;
`endif

endmodule

// File: tb/tb_divide_by_n.sv
// Self-checking bench for divide_by_n: hand-derived vector table, a 255-cycle
// square-wave sequence, and randomized traffic against a behavioural model.
module tb_divide_by_n;

    logic       clk = 1'b0;
    logic       reset, en, div_load, mode_in;
    logic [7:0] div_in;
    logic       y, tick, busy;
`ifdef DIVN_PHASE_OUT_EN
    logic [7:0] phase;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit checksOn    = 1'b0;
    logic obsY, obsTick, obsBusy;

    // Behavioural model: position within the current period plus active/pending settings.
    int mPos, mDiv, mMode, mPDiv, mPMode;
    bit mPV;

    typedef struct {
        bit rst;
        bit en;
        bit ld;
        int div;
        bit mode;
        bit expY;
        bit expTick;
        bit expBusy;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    divide_by_n #(.WIDTH(8), .DEFAULT_DIV(3), .DEFAULT_MODE(0)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .div_load(div_load),
        .div_in  (div_in),
        .mode_in (mode_in),
        .y       (y),
        .tick    (tick),
        .busy    (busy)
`ifdef DIVN_PHASE_OUT_EN
        ,
        .phase   (phase)
`endif
    );

    function automatic int modelN();
        return (mDiv == 0) ? 1 : mDiv;
    endfunction

    function automatic bit modelY();
        if (mMode != 0) return mPos < (modelN() + 1) / 2;
        return mPos == 0;
    endfunction

    task automatic modelStep(input bit r, input bit e, input bit l, input int d, input bit m);
        bit endOfPeriod;
        bit idleAtZero;
        if (r) begin
            mPos = 0; mDiv = 3; mMode = 0; mPV = 0;
            return;
        end
        endOfPeriod = e && (mPos == modelN() - 1);
        idleAtZero  = !e && (mPos == 0);
        if (e) mPos = (mPos + 1) % modelN();
        if (endOfPeriod || idleAtZero) begin
            if (l) begin
                mDiv = d; mMode = m;
            end else if (mPV) begin
                mDiv = mPDiv; mMode = mPMode;
            end
            mPV = 0;
        end else if (l) begin
            mPDiv = d; mPMode = m; mPV = 1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit l, input int d, input bit m);
        @(negedge clk);
        reset    = r;
        en       = e;
        div_load = l;
        div_in   = 8'(d);
        mode_in  = m;
        #1;
        obsY    = y;
        obsTick = tick;
        obsBusy = busy;
        if (checksOn) begin
            checkOutput("model_y", {31'd0, obsY}, {31'd0, modelY()});
            checkOutput("model_tick", {31'd0, obsTick}, {31'd0, e && (mPos == modelN() - 1)});
            checkOutput("model_busy", {31'd0, obsBusy}, {31'd0, mPV});
`ifdef DIVN_PHASE_OUT_EN
            checkOutput("model_phase", {24'd0, phase}, 32'(mPos));
`endif
        end
        modelStep(r, e, l, d, m);
    endtask

    function automatic void addVec(input bit r, input bit e, input bit l, input int d, input bit m,
                                   input bit ey, input bit et, input bit eb);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.div = d; v.mode = m;
        v.expY = ey; v.expTick = et; v.expBusy = eb;
        vecs.push_back(v);
    endfunction

    initial begin
        int highs, firstLow, ticks, waitCount;
        bit lastTick, seenApply;

        reset = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0; mode_in = 1'b0;

        // Defaults after reset: N=3 pulse
        addVec(0,1,0,0,0, 1,0,0); addVec(0,1,0,0,0, 0,0,0); addVec(0,1,0,0,0, 0,1,0);
        addVec(0,1,0,0,0, 1,0,0);
        // Load N=4 square at cnt=1; applies at the wrap
        addVec(0,1,1,4,1, 0,0,0); addVec(0,1,0,0,0, 0,1,1);
        addVec(0,1,0,0,0, 1,0,0); addVec(0,1,0,0,0, 1,0,0); addVec(0,1,0,0,0, 0,0,0);
        addVec(0,1,0,0,0, 0,1,0); addVec(0,1,0,0,0, 1,0,0);
        // Load N=0 pulse: behaves as N=1
        addVec(0,1,1,0,0, 1,0,0); addVec(0,1,0,0,0, 0,0,1); addVec(0,1,0,0,0, 0,1,1);
        addVec(0,1,0,0,0, 1,1,0); addVec(0,1,0,0,0, 1,1,0); addVec(0,0,0,0,0, 1,0,0);
        // Idle load at cnt=0 applies next edge; then en drop at cnt=2 for N=5
        addVec(0,0,1,5,0, 1,0,0);
        addVec(0,1,0,0,0, 1,0,0); addVec(0,1,0,0,0, 0,0,0);
        addVec(0,0,0,0,0, 0,0,0); addVec(0,0,0,0,0, 0,0,0);
        addVec(0,0,0,0,0, 0,0,0); addVec(0,0,0,0,0, 0,0,0);
        addVec(0,1,0,0,0, 0,0,0); addVec(0,1,0,0,0, 0,0,0); addVec(0,1,0,0,0, 0,1,0);
        addVec(0,1,0,0,0, 1,0,0); addVec(0,1,0,0,0, 0,0,0); addVec(0,1,0,0,0, 0,0,0);
        addVec(0,1,0,0,0, 0,0,0);
        // Load N=6 exactly in the tick cycle: bypass
        addVec(0,1,1,6,0, 0,1,0);
        addVec(0,1,0,0,0, 1,0,0);
        // Back-to-back loads 7 then 2: only 2 applies
        addVec(0,1,1,7,0, 0,0,0); addVec(0,1,1,2,0, 0,0,1);
        addVec(0,1,0,0,0, 0,0,1); addVec(0,1,0,0,0, 0,0,1); addVec(0,1,0,0,0, 0,1,1);
        addVec(0,1,0,0,0, 1,0,0); addVec(0,1,0,0,0, 0,1,0);
        // Reset mid-period with a load pending
        addVec(0,1,1,9,1, 1,0,0); addVec(1,1,0,0,0, 0,1,1);
        addVec(0,1,0,0,0, 1,0,0); addVec(0,1,0,0,0, 0,0,0); addVec(0,1,0,0,0, 0,1,0);

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 9, 1);
        checksOn = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].div, vecs[i].mode);
            checkOutput($sformatf("vec%0d_y", i), {31'd0, obsY}, {31'd0, vecs[i].expY});
            checkOutput($sformatf("vec%0d_tick", i), {31'd0, obsTick}, {31'd0, vecs[i].expTick});
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, obsBusy}, {31'd0, vecs[i].expBusy});
        end

        // N=255 square: 128 high cycles then 127 low, one tick at the end
        applyStimulus(0, 1, 1, 255, 1);
        seenApply = 1'b0;
        waitCount = 0;
        while (!seenApply && waitCount < 10) begin
            applyStimulus(0, 1, 0, 0, 0);
            seenApply = obsTick;
            waitCount++;
        end
        checkOutput("n255_apply_seen", {31'd0, seenApply}, 32'd1);
        highs = 0; firstLow = -1; ticks = 0; lastTick = 1'b0;
        for (int c = 0; c < 255; c++) begin
            applyStimulus(0, 1, 0, 0, 0);
            if (obsY) highs++;
            else if (firstLow < 0) firstLow = c;
            if (obsTick) ticks++;
            lastTick = obsTick;
        end
        checkOutput("n255_highs", 32'(highs), 32'd128);
        checkOutput("n255_first_low", 32'(firstLow), 32'd128);
        checkOutput("n255_ticks", 32'(ticks), 32'd1);
        checkOutput("n255_last_tick", {31'd0, lastTick}, 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int d;
            d = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 9));
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0,
                          d,
                          $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
